fifo_access_ctrl: RTL and testbench
===================================

Name: fifo_access_ctrl

Overview:
- Synchronous controller that shares one FIFO write port among NUM_REQ producers and schedules one consumer read port.
- The FIFO it drives is edge-triggered on its wclk/rclk/rst strobes. This block turns a system clock into clean single-cycle strobe pulses, each followed by a mandatory low cycle.
- Sits between producer/consumer logic and the FIFO instance.
- Keeps its own occupancy count so the strobes never depend on the FIFO's combinational flags.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- DATO_WIDTH, 3, data word width.
- FIFO_LENGTH, 5, depth of the controlled FIFO.
- MAX_BURST, 4, maximum consecutive writes per grant. Used only with FIFO_ARB_BURST_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- req  in  NUM_REQ  write request per producer.
- req_data  in  NUM_REQ*DATO_WIDTH  producer data. Slice i belongs to req[i].
- ack  out  NUM_REQ  one-cycle write-done pulse per producer.
- rd_req  in  1  consumer read request.
- rd_ack  out  1  one-cycle read-done pulse.
- fifo_wr  out  1  FIFO wclk strobe.
- fifo_rd  out  1  FIFO rclk strobe.
- fifo_rst  out  1  FIFO rst strobe.
- fifo_datin  out  DATO_WIDTH  FIFO write data, registered.
- level  out  clog2(FIFO_LENGTH+1)  tracked occupancy.

Behaviour:
- Reset rst is synchronous and active-high.
- While rst is high:
  - state=INIT, level=0, rr_ptr=0.
  - ack=0, rd_ack=0, fifo_wr=0, fifo_rd=0, fifo_datin=0.
  - fifo_rst=1.
- Reset mid-operation: takes effect at the next edge from any state. Any strobe in progress drops, its ack is not issued, and level returns to 0.
- FSM states:
  - INIT: fifo_rst=1 for exactly one cycle after rst falls, then go to ARB.
  - ARB: evaluate the two candidates below. If either exists, register the decision (wr_go, rd_go, winner index), latch req_data[winner] into fifo_datin, and go to STROBE. Otherwise stay in ARB.
    - wr_cand: any req, and (level<FIFO_LENGTH or rd_go).
    - rd_cand: rd_req and level>0.
  - STROBE, one cycle: fifo_wr=wr_go, fifo_rd=rd_go, ack[winner]=wr_go, rd_ack=rd_go. Go to GAP.
  - GAP, one cycle: all strobes low. Go to ARB.
- Latency: a request sampled in ARB at edge t produces its strobe and ack in cycle t+1.
- Throughput: one transaction (write, read, or both) per 3 cycles.
- Level update on STROBE:
  - Write only: +1.
  - Read only: -1.
  - Both: unchanged.
  - Never exceeds FIFO_LENGTH and never underflows.
- Boundary conditions:
  - Full with write only: no strobe and no ack; the requester keeps waiting.
  - Full with write and read: both strobes are issued in the same cycle.
  - Empty with read only: no strobe.
  - Empty with write and read: only the write is issued. The read follows on a later pass.
- Round robin:
  - Search starts at rr_ptr and wraps modulo NUM_REQ. The first asserted req wins.
  - After a write, rr_ptr = winner+1, with the wrap.
- Handshake: a producer holds req and req_data stable until its ack. It may deassert in the cycle after ack.

Optional Feature:
- Macro FIFO_ARB_BURST_EN.
- Defined:
  - The winner keeps the grant on subsequent ARB passes while its req stays high and it has written fewer than MAX_BURST words.
  - rr_ptr advances only when the burst ends: req dropped, MAX_BURST reached, or write blocked by full.
  - A burst counter resets on each new grant.
- Undefined: pure round robin. rr_ptr advances after every write and there is no burst counter.

Decomposition:
- Package fifo_arb_pkg holds:
  - State encoding (INIT, ARB, STROBE, GAP).
  - A clog2 function and the LEVEL_W constant.
- Sub-module rr_picker: combinational rotate-priority encoder. Inputs req and rr_ptr; outputs valid and winner index.

Test Plan:
- Reset: rst high for 2 cycles, then low -> fifo_rst high for those 2 cycles plus 1. level=0, all strobes and acks 0.
- req[2]=1 with data 3'b101 from ARB -> next cycle fifo_wr=1, fifo_datin=101, ack[2]=1, level=1. GAP cycle all strobes 0.
- req=4'b1111 held, no burst -> grant order 0,1,2,3,0, one strobe every 3 cycles. level saturates at 5 and further writes stall.
- level=5, req[1] and rd_req both high -> fifo_wr=1 and fifo_rd=1 in the same cycle, ack[1]=1, rd_ack=1, level stays 5.
- level=0, rd_req only -> fifo_rd never pulses and rd_ack=0. Then req[0]=1 with rd_req=1 -> write only, level=1, then a read on the next pass returns level to 0.
- rst asserted during STROBE -> next cycle fifo_wr=0, ack=0, level=0, fifo_rst=1. With FIFO_ARB_BURST_EN: req[0] held -> 4 consecutive writes to requester 0, then the grant moves to requester 1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO access controller.
// State encoding for the strobe scheduler, a constant clog2 and the default occupancy width.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ARB    = 2'd1,
    ST_STROBE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int FIFO_LENGTH_DEF = 5;
  localparam int LEVEL_W         = clog2(FIFO_LENGTH_DEF + 1);

endpackage

// File: rtl/fifo_access_ctrl_if.sv
// Producer/consumer/FIFO-side signal bundle for fifo_access_ctrl.
// The master modport is the producer/consumer side; the slave modport is the controller.
interface fifo_access_ctrl_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATO_WIDTH = 3,
  parameter int LEVEL_W    = 3
);

  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*DATO_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_ack;
  logic                          i_rd_req;
  logic                          o_rd_ack;
  logic                          o_fifo_wr;
  logic                          o_fifo_rd;
  logic                          o_fifo_rst;
  logic [DATO_WIDTH-1:0]         o_fifo_datin;
  logic [LEVEL_W-1:0]            o_level;

  modport master (
    output i_req, i_req_data, i_rd_req,
    input  o_ack, o_rd_ack, o_fifo_wr, o_fifo_rd, o_fifo_rst, o_fifo_datin, o_level
  );

  modport slave (
    input  i_req, i_req_data, i_rd_req,
    output o_ack, o_rd_ack, o_fifo_wr, o_fifo_rd, o_fifo_rst, o_fifo_datin, o_level
  );

endinterface

// File: rtl/fifo_access_ctrl_rr_picker.sv
// Combinational rotate-priority encoder: first asserted request at or after i_ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic               o_valid,
  output logic [PW-1:0]      o_winner
);

  // Walk from the farthest offset back to the pointer so the closest request wins last.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      automatic int idx = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[idx]) begin
        o_valid  = 1'b1;
        o_winner = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Shares one FIFO write port among NUM_REQ producers and schedules the read port, emitting
// single-cycle strobes followed by a low cycle. Optional burst grants: define FIFO_ARB_BURST_EN.
module fifo_access_ctrl
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATO_WIDTH  = 3,
  parameter int FIFO_LENGTH = 5
`ifdef FIFO_ARB_BURST_EN
  , parameter int MAX_BURST = 4
`endif
) (
  input logic               clk,
  input logic               rst,
  fifo_access_ctrl_if.slave bus
);

  localparam int LW = clog2(FIFO_LENGTH + 1);
  localparam int PW = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
  localparam logic [LW-1:0] FULL = LW'(FIFO_LENGTH);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  state_e                r_state;
  logic [PW-1:0]         r_rr_ptr;
  logic [LW-1:0]         r_level;
  logic [NUM_REQ-1:0]    r_ack;
  logic                  r_rd_ack;
  logic                  r_fifo_wr;
  logic                  r_fifo_rd;
  logic                  r_fifo_rst;
  logic [DATO_WIDTH-1:0] r_fifo_datin;

  logic                  w_valid;
  logic [PW-1:0]         w_winner;
  logic                  w_rd_cand;
  logic                  w_wr_cand;
  logic [DATO_WIDTH-1:0] w_data;
  logic [NUM_REQ-1:0]    w_onehot;

`ifdef FIFO_ARB_BURST_EN
  localparam int BW = clog2(MAX_BURST + 1);
  logic          r_burst_live;
  logic [PW-1:0] r_burst_owner;
  logic [BW-1:0] r_burst_cnt;
  logic [BW-1:0] w_burst_next;
`endif

  function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + 1'b1;
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_picker (
    .i_req    (bus.i_req),
    .i_ptr    (r_rr_ptr),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  // A read frees a slot in the same strobe, so a full FIFO still accepts a paired write.
  assign w_rd_cand = bus.i_rd_req && (r_level != '0);
  assign w_wr_cand = w_valid && ((r_level < FULL) || w_rd_cand);

  always_comb begin
    w_data   = '0;
    w_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == PW'(i)) begin
        w_data      = bus.i_req_data[i*DATO_WIDTH +: DATO_WIDTH];
        w_onehot[i] = 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  // The pointer parks on the owner during a burst, so the picker re-selects it while its req holds.
  assign w_burst_next = (r_burst_live && (w_winner == r_burst_owner)) ? r_burst_cnt + 1'b1 : BW'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_rr_ptr     <= '0;
      r_level      <= '0;
      r_ack        <= '0;
      r_rd_ack     <= 1'b0;
      r_fifo_wr    <= 1'b0;
      r_fifo_rd    <= 1'b0;
      r_fifo_rst   <= 1'b1;
      r_fifo_datin <= '0;
`ifdef FIFO_ARB_BURST_EN
      r_burst_live  <= 1'b0;
      r_burst_owner <= '0;
      r_burst_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_INIT: begin
          r_fifo_rst <= 1'b1;
          r_state    <= ST_ARB;
        end
        ST_ARB: begin
          r_fifo_rst <= 1'b0;
          if (w_wr_cand || w_rd_cand) begin
            r_fifo_wr <= w_wr_cand;
            r_fifo_rd <= w_rd_cand;
            r_rd_ack  <= w_rd_cand;
            r_ack     <= w_wr_cand ? w_onehot : '0;
            if (w_wr_cand) begin
              r_fifo_datin <= w_data;
`ifdef FIFO_ARB_BURST_EN
              if (w_burst_next == BW'(MAX_BURST)) begin
                r_burst_live <= 1'b0;
                r_rr_ptr     <= incPtr(w_winner);
              end else begin
                r_burst_live  <= 1'b1;
                r_burst_owner <= w_winner;
                r_burst_cnt   <= w_burst_next;
                r_rr_ptr      <= w_winner;
              end
`else
              r_rr_ptr <= incPtr(w_winner);
`endif
            end
            if (w_wr_cand && !w_rd_cand) begin
              r_level <= r_level + 1'b1;
            end else if (!w_wr_cand && w_rd_cand) begin
              r_level <= r_level - 1'b1;
            end
            r_state <= ST_STROBE;
          end
`ifdef FIFO_ARB_BURST_EN
          else if (r_burst_live && w_valid) begin
            r_burst_live <= 1'b0;
            r_rr_ptr     <= incPtr(r_burst_owner);
          end
`endif
        end
        ST_STROBE: begin
          r_fifo_wr <= 1'b0;
          r_fifo_rd <= 1'b0;
          r_rd_ack  <= 1'b0;
          r_ack     <= '0;
          r_state   <= ST_GAP;
        end
        ST_GAP: begin
          r_state <= ST_ARB;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.o_ack        = r_ack;
  assign bus.o_rd_ack     = r_rd_ack;
  assign bus.o_fifo_wr    = r_fifo_wr;
  assign bus.o_fifo_rd    = r_fifo_rd;
  assign bus.o_fifo_rst   = r_fifo_rst;
  assign bus.o_fifo_datin = r_fifo_datin;
  assign bus.o_level      = r_level;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Randomized scoreboard bench for fifo_access_ctrl; honours FIFO_ARB_BURST_EN when defined.
module tb_fifo_access_ctrl;
  import fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 3;
  localparam int FL = 5;
  localparam int LW = clog2(FL + 1);
`ifdef FIFO_ARB_BURST_EN
  localparam int MB = 4;
`endif

  typedef struct {
    int cyc;
    bit wr;
    bit rd;
    int win;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_access_ctrl_if #(.NUM_REQ(NR), .DATO_WIDTH(DW), .LEVEL_W(LW)) bus ();

  fifo_access_ctrl #(
    .NUM_REQ     (NR),
    .DATO_WIDTH  (DW),
    .FIFO_LENGTH (FL)
`ifdef FIFO_ARB_BURST_EN
    , .MAX_BURST (MB)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  exp_t sbq[$];
  int   cyc = 0;
  int   mLevel = 0;
  int   mStart = 0;
  bit   mInit = 1'b0;
  bit   mRst = 1'b1;
  int   cool = 0;
  bit   started = 1'b0;
`ifdef FIFO_ARB_BURST_EN
  bit   live = 1'b0;
  int   owner = 0;
  int   cnt = 0;
`endif

  int   raisePct = 0;
  int   keepPct = 0;
  int   readPct = 0;
  bit   dirRd = 1'b0;
  int   dirSeq = 0;
  int   dirMask = 0;
  int   dirData = 0;
  int   lastSeq = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // One negedge step of the producers and the consumer, obeying the hold-until-ack handshake.
  task automatic applyStimulus();
    for (int i = 0; i < NR; i++) begin
      if (bus.i_req[i] && bus.o_ack[i]) begin
        if ($urandom_range(99) < keepPct) bus.i_req_data[i*DW +: DW] = DW'($urandom);
        else bus.i_req[i] = 1'b0;
      end else if (!bus.i_req[i]) begin
        if (dirSeq != lastSeq && dirMask[i]) begin
          bus.i_req[i] = 1'b1;
          bus.i_req_data[i*DW +: DW] = DW'(dirData);
        end else if ($urandom_range(99) < raisePct) begin
          bus.i_req[i] = 1'b1;
          bus.i_req_data[i*DW +: DW] = DW'($urandom);
        end
      end
    end
    lastSeq = dirSeq;
    bus.i_rd_req = dirRd || ($urandom_range(99) < readPct);
  endtask

  // Transaction-level reference: one decision per free slot, computed from occupancy and request order.
  task automatic modelArb();
    bit rdc;
    bit wrc;
    int w;
    rdc = bus.i_rd_req && (mLevel > 0);
    w = -1;
`ifdef FIFO_ARB_BURST_EN
    if (live && !bus.i_req[owner]) begin
      live = 1'b0;
      mStart = (owner + 1) % NR;
    end
    if (live) w = owner;
`endif
    for (int k = 0; k < NR; k++) begin
      if (w < 0 && bus.i_req[(mStart + k) % NR]) w = (mStart + k) % NR;
    end
    wrc = (w >= 0) && ((mLevel < FL) || rdc);
    if (!wrc && !rdc) begin
`ifdef FIFO_ARB_BURST_EN
      if (live && w >= 0) begin
        live = 1'b0;
        mStart = (owner + 1) % NR;
      end
`endif
      return;
    end
    sbq.push_back('{cyc: cyc, wr: wrc, rd: rdc, win: w,
                    data: wrc ? int'(bus.i_req_data[w*DW +: DW]) : 0});
    if (wrc) begin
`ifdef FIFO_ARB_BURST_EN
      if (live && w == owner) cnt++;
      else begin
        cnt = 1;
        owner = w;
      end
      if (cnt == MB) begin
        live = 1'b0;
        mStart = (w + 1) % NR;
      end else begin
        live = 1'b1;
      end
`else
      mStart = (w + 1) % NR;
`endif
    end
    if (wrc && !rdc) mLevel++;
    if (rdc && !wrc) mLevel--;
    cool = 2;
  endtask

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (rst) begin
      mLevel = 0;
      mStart = 0;
      mInit  = 1'b1;
      mRst   = 1'b1;
      cool   = 0;
`ifdef FIFO_ARB_BURST_EN
      live   = 1'b0;
`endif
    end else if (mInit) begin
      mInit = 1'b0;
      mRst  = 1'b1;
    end else begin
      mRst = 1'b0;
      if (cool > 0) cool--;
      else modelArb();
    end
  end

  // Monitor: every cycle checks occupancy and fifo_rst; any strobe or ack pops the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("level", int'(bus.o_level), mLevel);
      checkOutput("fifo_rst", int'(bus.o_fifo_rst), int'(mRst));
      if (bus.o_fifo_wr || bus.o_fifo_rd || bus.o_rd_ack || (bus.o_ack != '0)) begin
        if (sbq.size() == 0) begin
          checkOutput("spurious_strobe", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("strobe_cycle", cyc, e.cyc);
          checkOutput("fifo_wr", int'(bus.o_fifo_wr), int'(e.wr));
          checkOutput("fifo_rd", int'(bus.o_fifo_rd), int'(e.rd));
          checkOutput("rd_ack", int'(bus.o_rd_ack), int'(e.rd));
          checkOutput("ack", int'(bus.o_ack), e.wr ? (1 << e.win) : 0);
          if (e.wr) checkOutput("fifo_datin", int'(bus.o_fifo_datin), e.data);
        end
      end else begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          void'(sbq.pop_front());
          checkOutput("missing_strobe", 0, 1);
        end
      end
    end
  end

  initial begin
    bus.i_req = '0;
    bus.i_req_data = '0;
    bus.i_rd_req = 1'b0;
    forever begin
      @(negedge clk);
      applyStimulus();
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;

    repeat (2) @(negedge clk);
    checkOutput("reset_fifo_rst", int'(bus.o_fifo_rst), 1);
    checkOutput("reset_strobes", int'({bus.o_fifo_wr, bus.o_fifo_rd, bus.o_rd_ack}), 0);
    checkOutput("reset_ack", int'(bus.o_ack), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("init_fifo_rst", int'(bus.o_fifo_rst), 1);

    dirData = 5;
    dirMask = 4'b0100;
    dirSeq++;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_ack[2]) seen = 1'b1;
    end
    checkOutput("dir_ack2_seen", int'(seen), 1);
    checkOutput("dir_datin", int'(bus.o_fifo_datin), 5);
    checkOutput("dir_level", int'(bus.o_level), 1);
    @(negedge clk);
    checkOutput("dir_gap_wr", int'(bus.o_fifo_wr), 0);

    raisePct = 100; keepPct = 100; readPct = 0;
    repeat (60) @(negedge clk);
    checkOutput("saturated_level", int'(bus.o_level), FL);

    readPct = 100;
    repeat (30) @(negedge clk);
    checkOutput("full_rw_level", int'(bus.o_level), FL);

    raisePct = 0; keepPct = 0;
    repeat (45) @(negedge clk);
    checkOutput("drained_level", int'(bus.o_level), 0);
    repeat (10) @(negedge clk);

    dirData = int'($urandom_range(7));
    dirMask = 4'b0001;
    dirSeq++;
    repeat (15) @(negedge clk);
    checkOutput("empty_rw_level", int'(bus.o_level), 0);

    raisePct = 50; keepPct = 50; readPct = 40;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_fifo_wr) seen = 1'b1;
    end
    checkOutput("wait_strobe", int'(seen), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_fifo_wr", int'(bus.o_fifo_wr), 0);
    checkOutput("midrst_ack", int'(bus.o_ack), 0);
    checkOutput("midrst_level", int'(bus.o_level), 0);
    checkOutput("midrst_fifo_rst", int'(bus.o_fifo_rst), 1);
    rst = 1'b0;

    for (int blk = 0; blk < 6; blk++) begin
      raisePct = int'($urandom_range(90, 10));
      keepPct  = int'($urandom_range(80));
      readPct  = int'($urandom_range(90, 10));
      repeat (250) @(negedge clk);
    end

    raisePct = 0; keepPct = 0; readPct = 100;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    keepPct = 100;
    dirMask = 4'b0011;
    dirSeq++;
    repeat (60) @(negedge clk);

    keepPct = 0; readPct = 0;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
